dac_cmd_scheduler: RTL and testbench

DAC_CMD_SCHEDULER -- requirements
Module: dac_cmd_scheduler

---
 rtl/dac_cmd_scheduler_if.sv | 46 ++++
 rtl/dac_cmd_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_dac_cmd_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_cmd_scheduler_if.sv
// Request, command and status bundle between the DAC command scheduler and its environment.
// master = scheduler side, slave = requesters plus downstream command consumer.
interface dac_cmd_scheduler_if #(
    parameter int CMD_WIDTH   = 5,
    parameter int BATCH_WIDTH = 256,
    parameter int SCALE_WIDTH = 4
);
    logic                   req_rst;
    logic                   req_halt;
    logic                   req_pwl;
    logic                   req_seed;
    logic                   req_trig;
    logic                   req_scale;
    logic [BATCH_WIDTH-1:0] seed_in;
    logic [SCALE_WIDTH-1:0] scale_in;
    logic                   pwl_rdy;

    // Command handshake: cmd_valid rises together with cmd_code/cmd_seed/cmd_scale, all four stay
    // stable while cmd_valid=1 and cmd_rdy=0, and the command transfers on the edge where both are 1.
    logic                   cmd_rdy;
    logic                   cmd_done;
    logic [CMD_WIDTH-1:0]   cmd_code;
    logic [BATCH_WIDTH-1:0] cmd_seed;
    logic [SCALE_WIDTH-1:0] cmd_scale;
    logic                   cmd_valid;

    logic [5:0]             pending;
    logic                   busy;
    logic                   done_pulse;
    logic                   timeout_err;
    logic [1:0]             dbg_state;

    modport master (
        input  req_rst, req_halt, req_pwl, req_seed, req_trig, req_scale,
        input  seed_in, scale_in, pwl_rdy, cmd_rdy, cmd_done,
        output cmd_code, cmd_seed, cmd_scale, cmd_valid,
        output pending, busy, done_pulse, timeout_err, dbg_state
    );

    modport slave (
        output req_rst, req_halt, req_pwl, req_seed, req_trig, req_scale,
        output seed_in, scale_in, pwl_rdy, cmd_rdy, cmd_done,
        input  cmd_code, cmd_seed, cmd_scale, cmd_valid,
        input  pending, busy, done_pulse, timeout_err, dbg_state
    );
endinterface

// File: rtl/dac_cmd_scheduler.sv
// Collects single-cycle DAC control requests into pending bits and issues them one at a time,
// highest priority first, over a valid/ready command port with completion timeout.
module dac_cmd_scheduler #(
    parameter int CMD_WIDTH      = 5,
    parameter int BATCH_WIDTH    = 256,
    parameter int SCALE_WIDTH    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    dac_cmd_scheduler_if.master  io_bus
);

    // dbg_state encoding: 0 IDLE, 1 ISSUE, 2 WAIT_DONE, 3 WAIT_PWL
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_WAIT_PWL  = 2'd3
    } state_t;

    localparam int P_SCALE = 0;
    localparam int P_TRIG  = 1;
    localparam int P_SEED  = 2;
    localparam int P_PWL   = 3;
    localparam int P_HALT  = 4;
    localparam int P_RST   = 5;

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [5:0]             r_pending;
    logic [BATCH_WIDTH-1:0] r_seed_hold;
    logic [SCALE_WIDTH-1:0] r_scale_hold;
    logic [CMD_WIDTH-1:0]   r_cmd_code;
    logic [BATCH_WIDTH-1:0] r_cmd_seed;
    logic [SCALE_WIDTH-1:0] r_cmd_scale;
    logic                   r_cmd_valid;
    logic                   r_done_pulse;
    logic                   r_timeout_err;
    logic [CNT_W-1:0]       r_count;

    logic [5:0]             w_req;
    logic [5:0]             w_sel;
    logic [5:0]             w_issue_bits;
    logic [5:0]             w_clr;
    logic                   w_issue;
    logic                   w_handshake;
    logic                   w_done_evt;
    logic                   w_timeout_evt;
    logic [CMD_WIDTH-1:0]   w_code;

    assign w_req = {io_bus.req_rst, io_bus.req_halt, io_bus.req_pwl,
                    io_bus.req_seed, io_bus.req_trig, io_bus.req_scale};

    // Fixed priority rst > halt > pwl > seed > trig > scale.
    always_comb begin
        w_sel = '0;
        if (r_pending[P_RST])        w_sel[P_RST]   = 1'b1;
        else if (r_pending[P_HALT])  w_sel[P_HALT]  = 1'b1;
        else if (r_pending[P_PWL])   w_sel[P_PWL]   = 1'b1;
        else if (r_pending[P_SEED])  w_sel[P_SEED]  = 1'b1;
        else if (r_pending[P_TRIG])  w_sel[P_TRIG]  = 1'b1;
        else if (r_pending[P_SCALE]) w_sel[P_SCALE] = 1'b1;
    end

    always_comb begin
        w_state_next  = r_state;
        w_issue       = 1'b0;
        w_issue_bits  = '0;
        w_handshake   = 1'b0;
        w_done_evt    = 1'b0;
        w_timeout_evt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    if (w_sel[P_PWL] && !io_bus.pwl_rdy) begin
                        w_state_next = ST_WAIT_PWL;
                    end else begin
                        w_issue      = 1'b1;
                        w_issue_bits = w_sel;
                        w_state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (io_bus.cmd_rdy) begin
                    w_handshake  = 1'b1;
                    w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (io_bus.cmd_done) begin
                    w_done_evt   = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_count == CNT_LAST) begin
                    w_timeout_evt = 1'b1;
                    w_state_next  = ST_IDLE;
                end
            end
            ST_WAIT_PWL: begin
                // A pending rst/halt takes over; IDLE then picks it by priority.
                if (r_pending[P_RST] || r_pending[P_HALT]) begin
                    w_state_next = ST_IDLE;
                end else if (io_bus.pwl_rdy) begin
                    w_issue             = 1'b1;
                    w_issue_bits[P_PWL] = 1'b1;
                    w_state_next        = ST_ISSUE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_code    = '0;
        w_code[4] = w_issue_bits[P_RST];
        w_code[3] = w_issue_bits[P_HALT];
        w_code[2] = w_issue_bits[P_SEED];
        w_code[1] = w_issue_bits[P_TRIG];
        w_code[0] = w_issue_bits[P_PWL];
    end

    // Any issued command carries scale_hold, so pending scale is always retired with it.
    always_comb begin
        w_clr = '0;
        if (w_issue) begin
            w_clr          = w_issue_bits;
            w_clr[P_SCALE] = 1'b1;
            if (w_issue_bits[P_HALT] || w_issue_bits[P_RST]) begin
                w_clr[P_PWL]  = 1'b1;
                w_clr[P_SEED] = 1'b1;
                w_clr[P_TRIG] = 1'b1;
            end
            if (w_issue_bits[P_RST]) begin
                w_clr[P_HALT] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending     <= '0;
            r_seed_hold   <= '0;
            r_scale_hold  <= '0;
            r_cmd_code    <= '0;
            r_cmd_seed    <= '0;
            r_cmd_scale   <= '0;
            r_cmd_valid   <= 1'b0;
            r_done_pulse  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_count       <= '0;
        end else begin
            // New requests are OR-ed in after clearing, so a coincident set wins.
            r_pending    <= (r_pending & ~w_clr) | w_req;
            r_done_pulse <= w_done_evt;

            if (io_bus.req_seed) begin
                r_seed_hold <= io_bus.seed_in;
            end
            if (io_bus.req_scale) begin
                r_scale_hold <= io_bus.scale_in;
            end

            if (w_issue) begin
                r_cmd_valid <= 1'b1;
                r_cmd_code  <= w_code;
                r_cmd_seed  <= r_seed_hold;
                r_cmd_scale <= r_scale_hold;
            end else if (w_handshake) begin
                r_cmd_valid <= 1'b0;
            end else if (w_done_evt || w_timeout_evt) begin
                r_cmd_code <= '0;
            end

            if (w_handshake) begin
                r_count <= '0;
            end else if (r_state == ST_WAIT_DONE) begin
                r_count <= r_count + 1'b1;
            end

            if (w_issue && w_issue_bits[P_RST]) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout_evt) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign io_bus.cmd_code    = r_cmd_code;
    assign io_bus.cmd_seed    = r_cmd_seed;
    assign io_bus.cmd_scale   = r_cmd_scale;
    assign io_bus.cmd_valid   = r_cmd_valid;
    assign io_bus.pending     = r_pending;
    // The completion cycle still counts as busy so done_pulse and busy end together.
    assign io_bus.busy        = (r_state != ST_IDLE) || r_done_pulse;
    assign io_bus.done_pulse  = r_done_pulse;
    assign io_bus.timeout_err = r_timeout_err;
    assign io_bus.dbg_state   = r_state;

endmodule

// File: tb/tb_dac_cmd_scheduler.sv
// Bench for dac_cmd_scheduler: vector table of request mixes plus cycle-exact corner sequences,
// with a downstream responder that checks each transferred command against an expected queue.
module tb_dac_cmd_scheduler;

    localparam int CW    = 5;
    localparam int BW    = 256;
    localparam int SW    = 4;
    localparam int TO    = 16;
    localparam int EXP_W = CW + BW + SW;
    localparam int NV    = 13;

    typedef logic [299:0] wide_t;

    // req bit order: {rst, halt, pwl, seed, trig, scale}
    typedef struct {
        logic [5:0]            req;
        logic [SW-1:0]         scale;
        int                    n_exp;
        logic [1:0][CW-1:0]    codes;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [BW-1:0]    m_seed;
    logic [SW-1:0]    m_scale;
    logic             rsp_rdy = 1'b1;
    int               rsp_lat = 2;
    int               done_timer;

    dac_cmd_scheduler_if #(.CMD_WIDTH(CW), .BATCH_WIDTH(BW), .SCALE_WIDTH(SW)) bus ();

    dac_cmd_scheduler #(
        .CMD_WIDTH(CW), .BATCH_WIDTH(BW), .SCALE_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input wide_t act, input wide_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] rand_seed();
        logic [BW-1:0] s;
        for (int w = 0; w < BW / 32; w++) s[w*32 +: 32] = $urandom();
        return s;
    endfunction

    function automatic vec_t mk(input logic [5:0] req, input logic [SW-1:0] sc, input int n,
                                input logic [CW-1:0] c0, input logic [CW-1:0] c1);
        vec_t v;
        v.req      = req;
        v.scale    = sc;
        v.n_exp    = n;
        v.codes[0] = c0;
        v.codes[1] = c1;
        return v;
    endfunction

    // Drive one request cycle and update the hold model, leaving the bench one cycle later.
    task automatic pulse(input logic [5:0] req, input logic [BW-1:0] seed, input logic [SW-1:0] sc);
        {bus.req_rst, bus.req_halt, bus.req_pwl, bus.req_seed, bus.req_trig, bus.req_scale} = req;
        bus.seed_in  = seed;
        bus.scale_in = sc;
        if (req[2]) m_seed = seed;
        if (req[0]) m_scale = sc;
        step();
        {bus.req_rst, bus.req_halt, bus.req_pwl, bus.req_seed, bus.req_trig, bus.req_scale} = '0;
    endtask

    task automatic push(input logic [CW-1:0] code);
        exp_q.push_back({code, m_seed, m_scale});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((bus.busy || bus.pending != 6'd0 || exp_q.size() != 0) && n < 200) begin
            step();
            n++;
        end
        check({name, " settle"}, wide_t'(n < 200), wide_t'(1'b1));
    endtask

    // Downstream responder and scoreboard: drives cmd_rdy/cmd_done, pops on every transfer.
    initial begin : responder
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] want;
        bus.cmd_rdy  = 1'b0;
        bus.cmd_done = 1'b0;
        done_timer   = 0;
        forever begin
            @(negedge clk);
            bus.cmd_done = 1'b0;
            if (rst) begin
                done_timer = 0;
            end else if (done_timer > 0) begin
                done_timer--;
                if (done_timer == 0) bus.cmd_done = 1'b1;
            end
            bus.cmd_rdy = rsp_rdy;
            if (!rst && bus.cmd_valid && bus.cmd_rdy) begin
                got = {bus.cmd_code, bus.cmd_seed, bus.cmd_scale};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got code=%b scale=%0d, no command expected",
                             bus.cmd_code, bus.cmd_scale);
                end else begin
                    want = exp_q.pop_front();
                    check("cmd_code", wide_t'(got[EXP_W-1 -: CW]), wide_t'(want[EXP_W-1 -: CW]));
                    check("cmd_seed_scale", wide_t'(got[BW+SW-1:0]), wide_t'(want[BW+SW-1:0]));
                end
                if (rsp_lat > 0) done_timer = rsp_lat;
            end
        end
    end

    initial begin : main
        vec_t        vecs[NV];
        logic [8:0]  vld;
        logic [8:0]  bsy;
        logic [8:0]  dp;
        logic [5:0]  pend1;
        logic [CW-1:0] code2;

        vecs[0]  = mk(6'b000010, 4'd1,  1, 5'b00010, 5'b00000);
        vecs[1]  = mk(6'b000100, 4'd2,  1, 5'b00100, 5'b00000);
        vecs[2]  = mk(6'b001000, 4'd3,  1, 5'b00001, 5'b00000);
        vecs[3]  = mk(6'b010000, 4'd4,  1, 5'b01000, 5'b00000);
        vecs[4]  = mk(6'b100000, 4'd5,  1, 5'b10000, 5'b00000);
        vecs[5]  = mk(6'b000001, 4'd5,  1, 5'b00000, 5'b00000);
        vecs[6]  = mk(6'b000110, 4'd6,  2, 5'b00100, 5'b00010);
        vecs[7]  = mk(6'b111111, 4'd12, 1, 5'b10000, 5'b00000);
        vecs[8]  = mk(6'b010111, 4'd9,  1, 5'b01000, 5'b00000);
        vecs[9]  = mk(6'b001011, 4'd14, 2, 5'b00001, 5'b00010);
        vecs[10] = mk(6'b000011, 4'd3,  1, 5'b00010, 5'b00000);
        vecs[11] = mk(6'b011000, 4'd0,  1, 5'b01000, 5'b00000);
        vecs[12] = mk(6'b100001, 4'd15, 1, 5'b10000, 5'b00000);

        // Reset
        rst = 1'b1;
        {bus.req_rst, bus.req_halt, bus.req_pwl, bus.req_seed, bus.req_trig, bus.req_scale} = '0;
        bus.seed_in  = '0;
        bus.scale_in = '0;
        bus.pwl_rdy  = 1'b1;
        m_seed  = '0;
        m_scale = '0;
        repeat (3) step();
        rst = 1'b0;
        repeat (5) step();
        check("rst pending",     wide_t'(bus.pending),     wide_t'(6'd0));
        check("rst cmd_valid",   wide_t'(bus.cmd_valid),   wide_t'(1'b0));
        check("rst cmd_code",    wide_t'(bus.cmd_code),    wide_t'(5'd0));
        check("rst cmd_seed",    wide_t'(bus.cmd_seed),    wide_t'(0));
        check("rst cmd_scale",   wide_t'(bus.cmd_scale),   wide_t'(4'd0));
        check("rst busy",        wide_t'(bus.busy),        wide_t'(1'b0));
        check("rst done_pulse",  wide_t'(bus.done_pulse),  wide_t'(1'b0));
        check("rst timeout_err", wide_t'(bus.timeout_err), wide_t'(1'b0));

        // Cycle-exact single trig: valid in cycle 2, done_pulse in 6, busy 2..6
        rsp_rdy = 1'b1;
        rsp_lat = 3;
        vld = '0; bsy = '0; dp = '0;
        pulse(6'b000010, m_seed, m_scale);
        push(5'b00010);
        pend1 = bus.pending;
        vld[1] = bus.cmd_valid; bsy[1] = bus.busy; dp[1] = bus.done_pulse;
        code2 = '0;
        for (int c = 2; c <= 8; c++) begin
            step();
            vld[c] = bus.cmd_valid;
            bsy[c] = bus.busy;
            dp[c]  = bus.done_pulse;
            if (c == 2) code2 = bus.cmd_code;
        end
        check("lat pending c1",  wide_t'(pend1), wide_t'(6'b000010));
        check("lat valid cyc",   wide_t'(vld),   wide_t'(9'b000000100));
        check("lat busy cyc",    wide_t'(bsy),   wide_t'(9'b001111100));
        check("lat done cyc",    wide_t'(dp),    wide_t'(9'b001000000));
        check("lat code c2",     wide_t'(code2), wide_t'(5'b00010));
        wait_idle("lat");

        // Vector table
        rsp_lat = 2;
        for (int i = 0; i < NV; i++) begin
            pulse(vecs[i].req, rand_seed(), vecs[i].scale);
            for (int k = 0; k < vecs[i].n_exp; k++) push(vecs[i].codes[k]);
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d pending", i), wide_t'(bus.pending), wide_t'(6'd0));
            check($sformatf("vec%0d drained", i), wide_t'(exp_q.size()), wide_t'(0));
        end

        // pwl waiting on pwl_rdy, preempted by halt three cycles after the request
        bus.pwl_rdy = 1'b0;
        pulse(6'b001000, m_seed, m_scale);
        step();
        check("wpwl state", wide_t'(bus.dbg_state), wide_t'(2'd3));
        check("wpwl busy",  wide_t'(bus.busy),      wide_t'(1'b1));
        step();
        pulse(6'b010000, m_seed, m_scale);
        push(5'b01000);
        wait_idle("preempt");
        check("preempt pending", wide_t'(bus.pending), wide_t'(6'd0));
        bus.pwl_rdy = 1'b1;
        repeat (5) step();
        check("preempt no pwl", wide_t'(bus.cmd_valid), wide_t'(1'b0));

        // pwl released by pwl_rdy after waiting
        bus.pwl_rdy = 1'b0;
        pulse(6'b001000, m_seed, m_scale);
        repeat (3) step();
        check("pwl held", wide_t'(bus.cmd_valid), wide_t'(1'b0));
        push(5'b00001);
        bus.pwl_rdy = 1'b1;
        wait_idle("pwl release");

        // Held command stays stable; seed/scale requests coalesce behind it
        rsp_rdy = 1'b0;
        pulse(6'b000010, m_seed, m_scale);
        push(5'b00010);
        step();
        pulse(6'b000100, rand_seed(), m_scale);
        pulse(6'b000101, rand_seed(), 4'd7);
        push(5'b00100);
        step();
        step();
        check("hold valid",   wide_t'(bus.cmd_valid), wide_t'(1'b1));
        check("hold code",    wide_t'(bus.cmd_code),  wide_t'(5'b00010));
        check("hold pending", wide_t'(bus.pending),   wide_t'(6'b000101));
        rsp_rdy = 1'b1;
        wait_idle("coalesce");

        // Completion timeout after TO cycles in WAIT_DONE, cleared by an issued rst command
        rsp_lat = 0;
        pulse(6'b000010, m_seed, m_scale);
        push(5'b00010);
        repeat (17) step();
        check("to before", wide_t'(bus.timeout_err), wide_t'(1'b0));
        check("to busy",   wide_t'(bus.busy),        wide_t'(1'b1));
        step();
        check("to set",    wide_t'(bus.timeout_err), wide_t'(1'b1));
        check("to idle",   wide_t'(bus.dbg_state),   wide_t'(2'd0));
        check("to nodone", wide_t'(bus.done_pulse),  wide_t'(1'b0));
        repeat (3) step();
        check("to sticky", wide_t'(bus.timeout_err), wide_t'(1'b1));
        rsp_lat = 2;
        pulse(6'b100000, m_seed, m_scale);
        push(5'b10000);
        wait_idle("to clear");
        check("to cleared", wide_t'(bus.timeout_err), wide_t'(1'b0));

        // Asynchronous reset in WAIT_DONE with pwl and trig pending
        rsp_lat = 0;
        pulse(6'b000101, rand_seed(), 4'd11);
        push(5'b00100);
        repeat (3) step();
        pulse(6'b001010, m_seed, m_scale);
        check("ar pending", wide_t'(bus.pending),   wide_t'(6'b001010));
        check("ar state",   wide_t'(bus.dbg_state), wide_t'(2'd2));
        #3;
        rst = 1'b1;
        #1;
        check("ar cmd_code",    wide_t'(bus.cmd_code),    wide_t'(5'd0));
        check("ar cmd_seed",    wide_t'(bus.cmd_seed),    wide_t'(0));
        check("ar cmd_scale",   wide_t'(bus.cmd_scale),   wide_t'(4'd0));
        check("ar cmd_valid",   wide_t'(bus.cmd_valid),   wide_t'(1'b0));
        check("ar pending0",    wide_t'(bus.pending),     wide_t'(6'd0));
        check("ar busy",        wide_t'(bus.busy),        wide_t'(1'b0));
        check("ar done_pulse",  wide_t'(bus.done_pulse),  wide_t'(1'b0));
        check("ar timeout_err", wide_t'(bus.timeout_err), wide_t'(1'b0));
        m_seed  = '0;
        m_scale = '0;
        step();
        step();
        rst = 1'b0;
        rsp_lat = 2;
        repeat (10) step();
        check("ar no issue",  wide_t'(bus.cmd_valid), wide_t'(1'b0));
        check("ar idle busy", wide_t'(bus.busy),      wide_t'(1'b0));
        pulse(6'b000010, m_seed, m_scale);
        push(5'b00010);
        wait_idle("post reset");

        check("final queue", wide_t'(exp_q.size()), wide_t'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
